bus_request_arbiter: RTL and testbench

//  Round-robin arbiter for the shared internal bus. Collects per-source bus requests and

---
 rtl/bus_request_arbiter_if.sv | 27 ++
 rtl/bus_request_arbiter.sv | 144 ++++++++++++++
 tb/tb_bus_request_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_request_arbiter_if.sv
// Request/grant bundle between the bus requesters and the arbiter.
// The master side is the arbiter; the slave side is the requester/encoder view.
interface bus_request_arbiter_if #(
    parameter int NUM_REQ = 24
);
    logic [NUM_REQ-1:0] req;
    logic [31:0]        grant;
    logic               grant_valid;
    logic [4:0]         owner_idx;
    logic               timeout;

    modport master (
        input  req,
        output grant,
        output grant_valid,
        output owner_idx,
        output timeout
    );

    modport slave (
        output req,
        input  grant,
        input  grant_valid,
        input  owner_idx,
        input  timeout
    );
endinterface

// File: rtl/bus_request_arbiter.sv
// Round-robin bus arbiter with bounded tenure and dead cycles between
// owners; the registered one-hot grant feeds the bus-select encoder.
module bus_request_arbiter #(
    parameter int NUM_REQ    = 24,
    parameter int MAX_HOLD   = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    bus_request_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_e;

    localparam logic [4:0] NO_OWNER = 5'd31;
    localparam logic [4:0] LAST_IDX = 5'(NUM_REQ - 1);
    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
    localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES - 1);

    state_e      state_q, state_d;
    logic [4:0]  owner_q, owner_d;
    logic [4:0]  rr_ptr_q, rr_ptr_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [31:0] grant_q, grant_d;
    logic        grant_valid_q, grant_valid_d;
    logic        timeout_q, timeout_d;

    logic [31:0] req_ext;
    logic [5:0]  scan;
    logic        win_found;
    logic [4:0]  win_idx;
    logic [4:0]  win_next;
    logic        arb_en;
    logic        owner_req;
    logic        hold_full;

    // Widen to 32 so any 5-bit index is in range.
    assign req_ext = 32'(bus.req);

    // First set request at or above rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = {1'b0, rr_ptr_q} + 6'(i);
            if (scan >= 6'(NUM_REQ)) begin
                scan = scan - 6'(NUM_REQ);
            end
            if (!win_found && req_ext[scan[4:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[4:0];
            end
        end
    end

    assign win_next  = (win_idx == LAST_IDX) ? 5'd0 : win_idx + 5'd1;
    assign owner_req = req_ext[owner_q];
    assign hold_full = (hold_cnt_q == HOLD_MAX);

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        hold_cnt_d    = hold_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        timeout_d     = 1'b0;
        arb_en        = 1'b0;

        unique case (state_q)
            IDLE: begin
                arb_en = 1'b1;
            end
            GRANT: begin
                if (!owner_req || hold_full) begin
                    state_d       = GAP;
                    owner_d       = NO_OWNER;
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    gap_cnt_d     = GAP_INIT;
                    // Dropping req on the expiry edge is a voluntary release.
                    timeout_d     = owner_req && hold_full;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            GAP: begin
                if (gap_cnt_q != 4'd0) begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end else begin
                    arb_en  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (arb_en && win_found) begin
            state_d       = GRANT;
            owner_d       = win_idx;
            rr_ptr_d      = win_next;
            hold_cnt_d    = 8'd1;
            grant_d       = 32'd1 << win_idx;
            grant_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            owner_q       <= NO_OWNER;
            rr_ptr_q      <= '0;
            hold_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.owner_idx   = owner_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_bus_request_arbiter.sv
// Bench for bus_request_arbiter: directed vector table, hand sequences,
// and random requests against a tenure-level reference model.
module tb_bus_request_arbiter;

    localparam int N    = 24;
    localparam int MAXH = 8;
    localparam int GAPC = 1;

    logic clk;
    logic reset;

    bus_request_arbiter_if #(.NUM_REQ(N)) bus ();

    bus_request_arbiter #(
        .NUM_REQ   (N),
        .MAX_HOLD  (MAXH),
        .GAP_CYCLES(GAPC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    typedef struct {
        bit          rst;
        logic [23:0] req;
        logic [31:0] g;
        logic [4:0]  o;
        bit          to;
    } vec_t;

    vec_t vecs[$];

    // Reference model: who owns the bus, how long, and gap cycles left.
    int m_owner;
    int m_held;
    int m_gap;
    int m_ptr;
    bit m_to;

    function automatic void add(bit rst, logic [23:0] req,
                                logic [31:0] g, logic [4:0] o, bit to);
        vec_t v;
        v.rst = rst;
        v.req = req;
        v.g   = g;
        v.o   = o;
        v.to  = to;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic chk_out(string tag, logic [31:0] g,
                           logic [4:0] o, bit to);
        chk({tag, ".grant"}, bus.grant, g);
        chk({tag, ".valid"}, 32'(bus.grant_valid), 32'(g != 0));
        chk({tag, ".owner"}, 32'(bus.owner_idx), 32'(o));
        chk({tag, ".timeout"}, 32'(bus.timeout), 32'(to));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        chk_out("reset", 32'd0, 5'd31, 1'b0);
        reset = 1'b0;
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_held  = 0;
        m_gap   = 0;
        m_ptr   = 0;
        m_to    = 1'b0;
    endfunction

    function automatic void model_edge(logic [23:0] r);
        bit found;
        m_to  = 1'b0;
        found = 1'b0;
        if (m_owner >= 0) begin
            if (!r[m_owner] || m_held == MAXH) begin
                m_to    = r[m_owner] && (m_held == MAXH);
                m_owner = -1;
                m_gap   = GAPC;
            end else begin
                m_held++;
            end
        end else if (m_gap > 1) begin
            m_gap--;
        end else begin
            m_gap = 0;
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (!found && r[k]) begin
                    found   = 1'b1;
                    m_owner = k;
                    m_held  = 1;
                    m_ptr   = (k + 1) % N;
                end
            end
        end
    endfunction

    task automatic chk_model(string tag);
        logic [31:0] eg;
        logic [4:0]  eo;
        eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        eo = (m_owner >= 0) ? 5'(m_owner) : 5'd31;
        chk_out(tag, eg, eo, m_to);
        chk({tag, ".onehot"}, 32'($onehot0(bus.grant)), 32'd1);
    endtask

    initial begin
        logic [23:0] r;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.req  = '0;
        #12;

        // Single request, then voluntary release.
        add(1, 24'h0, 32'h0, 5'd31, 0);
        add(0, 24'h000001, 32'h1, 5'd0, 0);
        add(0, 24'h0, 32'h0, 5'd31, 0);
        add(0, 24'h0, 32'h0, 5'd31, 0);
        // Two requesters, source 4 drops after two cycles.
        add(1, 24'h0, 32'h0, 5'd31, 0);
        add(0, 24'h000030, 32'h10, 5'd4, 0);
        add(0, 24'h000030, 32'h10, 5'd4, 0);
        add(0, 24'h000020, 32'h0, 5'd31, 0);
        add(0, 24'h000020, 32'h20, 5'd5, 0);
        add(0, 24'h0, 32'h0, 5'd31, 0);
        // Held request hits the tenure limit.
        add(1, 24'h0, 32'h0, 5'd31, 0);
        for (int i = 0; i < 8; i++) add(0, 24'h80, 32'h80, 5'd7, 0);
        add(0, 24'h80, 32'h0, 5'd31, 1);
        add(0, 24'h80, 32'h80, 5'd7, 0);
        // Wrap from source 23 to 0, then on to 22.
        add(1, 24'h0, 32'h0, 5'd31, 0);
        add(0, 24'h800000, 32'h800000, 5'd23, 0);
        add(0, 24'h400001, 32'h0, 5'd31, 0);
        add(0, 24'h400001, 32'h1, 5'd0, 0);
        add(0, 24'h400000, 32'h0, 5'd31, 0);
        add(0, 24'h400000, 32'h400000, 5'd22, 0);
        // Drop on the expiry edge is not a timeout.
        add(1, 24'h0, 32'h0, 5'd31, 0);
        for (int i = 0; i < 8; i++) add(0, 24'h2, 32'h2, 5'd1, 0);
        add(0, 24'h0, 32'h0, 5'd31, 0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) begin
                bus.req = '0;
                do_reset();
            end else begin
                bus.req = vecs[i].req;
                tick();
                chk_out($sformatf("vec%0d", i), vecs[i].g,
                        vecs[i].o, vecs[i].to);
            end
        end

        // All sources requesting: strict rotation with timeouts.
        bus.req = '0;
        do_reset();
        bus.req = 24'hFFFFFF;
        for (int k = 0; k < 25; k++) begin
            for (int c = 0; c < MAXH; c++) begin
                tick();
                chk_out($sformatf("rot%0d", k),
                        32'd1 << (k % N), 5'(k % N), 1'b0);
            end
            tick();
            chk_out($sformatf("rotgap%0d", k), 32'd0, 5'd31, 1'b1);
        end

        // Async reset in the middle of a tenure; pointer returns to 0.
        bus.req = '0;
        do_reset();
        bus.req = 24'h000020;
        tick();
        tick();
        chk_out("pre_rst", 32'h20, 5'd5, 1'b0);
        reset = 1'b1;
        #2;
        chk_out("mid_rst", 32'd0, 5'd31, 1'b0);
        bus.req = 24'h000101;
        reset   = 1'b0;
        tick();
        chk_out("post_rst_ptr", 32'h1, 5'd0, 1'b0);
        tick();
        reset = 1'b1;
        #2;
        chk_out("mid_rst2", 32'd0, 5'd31, 1'b0);
        bus.req = 24'h000100;
        reset   = 1'b0;
        tick();
        chk_out("post_rst8", 32'h100, 5'd8, 1'b0);

        // Random traffic against the model.
        bus.req = '0;
        do_reset();
        model_reset();
        r = '0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                r       = '0;
                bus.req = r;
                do_reset();
                model_reset();
            end else begin
                if ((n / 500) % 3 == 2) begin
                    r = 24'($urandom);
                end else begin
                    r = r ^ 24'($urandom & $urandom & $urandom & $urandom);
                end
                bus.req = r;
                tick();
                model_edge(r);
                chk_model($sformatf("rnd%0d", n));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
